// File: rtl/uart_snd_feeder.sv
// Transmit-side byte FIFO feeding a UART sender through its en/data/can_snd handshake.
// tx_data is held for the whole frame and changes only on a load while the sender is idle.
module uart_snd_feeder #(
    parameter int unsigned DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  clr_ovf,
    input  logic                  can_snd,
    output logic                  tx_en,
    output logic [7:0]            tx_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   level,
    output logic                  overflow,
    output logic                  busy
);

    localparam int unsigned DEPTH = 2 ** DEPTH_BITS;
    localparam int unsigned PW    = DEPTH_BITS + 1;

    typedef enum logic [1:0] {StIdle, StOffer, StBusy} state_e;

    state_e            state_q, state_d;
    logic [7:0]        mem [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;
    logic              tx_en_q, tx_en_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              push;
    logic              load;

    // Handshake FSM; load pops the head byte and raises tx_en in the same edge.
    always_comb begin
        state_d   = state_q;
        tx_en_d   = tx_en_q;
        tx_data_d = tx_data_q;
        load      = 1'b0;
        case (state_q)
            StIdle: begin
                tx_en_d = 1'b0;
                if (can_snd && !empty_q) begin
                    load = 1'b1;
                end
            end
            StOffer: begin
                if (!can_snd) begin
                    tx_en_d = 1'b0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                tx_en_d = 1'b0;
                if (can_snd) begin
                    if (!empty_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                tx_en_d = 1'b0;
                state_d = StIdle;
            end
        endcase
        if (load) begin
            tx_data_d = mem[rd_ptr_q[DEPTH_BITS-1:0]];
            tx_en_d   = 1'b1;
            state_d   = StOffer;
        end
    end

    // Full is the registered value, so a same-cycle pop never frees room for a write.
    always_comb begin
        push       = wr_en && !full_q;
        overflow_d = (overflow_q && !clr_ovf) || (wr_en && full_q);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(load);
        level_d    = wr_ptr_d - rd_ptr_d;
        full_d     = (level_d == PW'(DEPTH));
        empty_d    = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            tx_en_q    <= tx_en_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr_q[DEPTH_BITS-1:0]] <= wr_data;
        end
    end

    assign tx_en    = tx_en_q;
    assign tx_data  = tx_data_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_snd_feeder.sv
// Directed bench for uart_snd_feeder: handshake, ordering, overflow, wrap and reset.
module tb_uart_snd_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       can_snd;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    uart_snd_feeder #(.DEPTH_BITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .clr_ovf  (clr_ovf),
        .can_snd  (can_snd),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Sender model: accept each offered byte, then finish the frame.
    task automatic drain(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            can_snd = 1'b1;
            tick();
            check("drain_en", tx_en, 1);
            check("drain_data", tx_data, base + 8'(i));
            can_snd = 1'b0;
            tick();
            check("drain_en_low", tx_en, 0);
        end
        can_snd = 1'b1;
        tick();
        check("drain_idle", busy, 0);
        check("drain_empty", empty, 1);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'hFF; clr_ovf = 1'b0; can_snd = 1'b1;
        tick();
        tick();
        rst = 1'b0; wr_en = 1'b0;
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy", busy, 0);

        // Two-cycle latency from write to tx_en.
        wr_byte(8'hA5);
        check("lat_empty", empty, 0);
        check("lat_level", level, 1);
        check("lat_en0", tx_en, 0);
        tick();
        check("lat_en1", tx_en, 1);
        check("lat_data", tx_data, 8'hA5);
        check("lat_empty2", empty, 1);
        check("lat_level2", level, 0);

        can_snd = 1'b0;
        tick();
        check("acc_en", tx_en, 0);
        check("acc_busy", busy, 1);
        tick();
        check("busy_hold", busy, 1);
        can_snd = 1'b1;
        tick();
        check("idle_busy", busy, 0);
        check("idle_data", tx_data, 8'hA5);
        check("idle_en", tx_en, 0);

        // Three frames back to back.
        can_snd = 1'b0;
        wr_byte(8'h01);
        wr_byte(8'h02);
        wr_byte(8'h03);
        check("three_level", level, 3);
        check("three_idle_en", tx_en, 0);
        for (int i = 0; i < 3; i++) begin
            can_snd = 1'b1;
            tick();
            check("seq_en", tx_en, 1);
            check("seq_data", tx_data, 8'(i + 1));
            can_snd = 1'b0;
            tick();
            check("seq_en_low", tx_en, 0);
            check("seq_busy", busy, 1);
            check("seq_hold", tx_data, 8'(i + 1));
            tick();
            check("seq_en_low2", tx_en, 0);
            check("seq_hold2", tx_data, 8'(i + 1));
        end
        can_snd = 1'b1;
        tick();
        check("seq_idle", busy, 0);
        check("seq_last", tx_data, 8'h03);

        // Overflow with 17 writes into a 16-deep FIFO.
        can_snd = 1'b0;
        for (int i = 0; i < 16; i++) wr_byte(8'h10 + 8'(i));
        check("fill_full", full, 1);
        check("fill_level", level, 16);
        check("fill_ovf0", overflow, 0);
        wr_byte(8'hEE);
        check("drop_ovf", overflow, 1);
        check("drop_level", level, 16);
        clr_ovf = 1'b1;
        wr_byte(8'hEF);
        check("set_wins", overflow, 1);
        tick();
        clr_ovf = 1'b0;
        check("clr_ovf", overflow, 0);
        drain(16, 8'h10);

        // Second fill crosses the pointer wrap.
        can_snd = 1'b0;
        for (int i = 0; i < 16; i++) wr_byte(8'h40 + 8'(i));
        check("wrap_full", full, 1);
        drain(16, 8'h40);

        // Simultaneous write and load keep the level.
        can_snd = 1'b0;
        for (int i = 0; i < 5; i++) wr_byte(8'h60 + 8'(i));
        check("sim_level5", level, 5);
        can_snd = 1'b1;
        wr_byte(8'h65);
        check("sim_level", level, 5);
        check("sim_en", tx_en, 1);
        check("sim_data", tx_data, 8'h60);
        can_snd = 1'b0;
        tick();
        for (int i = 0; i < 11; i++) wr_byte(8'h66 + 8'(i));
        check("sim_full", full, 1);
        can_snd = 1'b1;
        wr_byte(8'hEE);
        check("full_drop_level", level, 15);
        check("full_drop_ovf", overflow, 1);
        check("full_drop_data", tx_data, 8'h61);
        can_snd = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            can_snd = 1'b1;
            tick();
            check("pre_rst_data", tx_data, 8'h62 + 8'(i));
            if (i < 7) begin
                can_snd = 1'b0;
                tick();
            end
        end
        check("offer_level", level, 7);
        check("offer_en", tx_en, 1);

        // Reset mid-offer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_en", tx_en, 0);
        check("mid_rst_data", tx_data, 8'h00);
        check("mid_rst_level", level, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
